// File: rtl/adc_mon_pkg.sv
// Shared types and constants for the ADC threshold monitor.
// Read by adc_threshold_monitor and adc_hysteresis_fsm.
package adc_mon_pkg;

  typedef enum logic [1:0] {
    StNormal,
    StPendHigh,
    StAlarm,
    StPendLow
  } mon_state_e;

  localparam int unsigned SampleWidth = 20;
  // Value the upstream counter pins at when the RC stage never trips.
  localparam logic [SampleWidth-1:0] SatValue = 20'hFFFFF;
  localparam int unsigned DebCntWidth = 4;
  localparam int unsigned IirShift = 3;

endpackage

// File: rtl/adc_hysteresis_fsm.sv
// Debounced hysteresis alarm: DEBOUNCE consecutive qualifying strobes enter or leave alarm.
// The FSM state, the debounce count and the alarm output are all registered.
module adc_hysteresis_fsm
  import adc_mon_pkg::*;
#(
  parameter int unsigned WIDTH    = SampleWidth,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             strobe,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] thresh_high,
  input  logic [WIDTH-1:0] thresh_low,
  output logic             alarm
);

  localparam logic [DebCntWidth-1:0] DebLimit = DebCntWidth'(DEBOUNCE);

  mon_state_e             state;
  logic [DebCntWidth-1:0] cnt;
  logic [DebCntWidth-1:0] cnt_inc;
  logic                   above;
  logic                   below;

  assign cnt_inc = cnt + DebCntWidth'(1);
  assign above   = value > thresh_high;
  assign below   = value < thresh_low;

  // cnt is zero in StNormal and StAlarm, so one compare also covers DEBOUNCE == 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= StNormal;
      cnt   <= '0;
      alarm <= 1'b0;
    end else if (strobe) begin
      unique case (state)
        StNormal, StPendHigh: begin
          if (!above) begin
            state <= StNormal;
            cnt   <= '0;
          end else if (cnt_inc == DebLimit) begin
            state <= StAlarm;
            cnt   <= '0;
            alarm <= 1'b1;
          end else begin
            state <= StPendHigh;
            cnt   <= cnt_inc;
          end
        end
        StAlarm, StPendLow: begin
          if (!below) begin
            state <= StAlarm;
            cnt   <= '0;
          end else if (cnt_inc == DebLimit) begin
            state <= StNormal;
            cnt   <= '0;
            alarm <= 1'b0;
          end else begin
            state <= StPendLow;
            cnt   <= cnt_inc;
          end
        end
        default: begin
          state <= StNormal;
          cnt   <= '0;
          alarm <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/adc_threshold_monitor.sv
// New-sample detector, min/max tracker, stale/saturation flags and hysteresis alarm.
// Define ADC_MON_IIR_EN to place a first-order IIR filter in front of the alarm FSM.
module adc_threshold_monitor
  import adc_mon_pkg::*;
#(
  parameter int unsigned WIDTH        = SampleWidth,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned STALE_CYCLES = 2097152
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] adc_count,
  input  logic [WIDTH-1:0] thresh_high,
  input  logic [WIDTH-1:0] thresh_low,
  input  logic             clear_minmax,
  output logic             sample_strobe,
  output logic [WIDTH-1:0] sample_value,
  output logic             alarm,
  output logic [WIDTH-1:0] min_value,
  output logic [WIDTH-1:0] max_value,
  output logic             stale,
  output logic             saturated
);

  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};
  localparam int unsigned StaleWidth = $clog2(STALE_CYCLES);
  localparam logic [StaleWidth-1:0] StaleMax = StaleWidth'(STALE_CYCLES - 1);

  logic [WIDTH-1:0]      prev_count;
  logic                  new_sample;
  logic [StaleWidth-1:0] stale_cnt;
  logic                  fsm_strobe;
  logic [WIDTH-1:0]      fsm_value;

  // The upstream count has no valid strobe; any change is taken as a new result.
  assign new_sample = adc_count != prev_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_count    <= '0;
      sample_strobe <= 1'b0;
      sample_value  <= '0;
      saturated     <= 1'b0;
    end else begin
      prev_count    <= adc_count;
      sample_strobe <= new_sample;
      if (new_sample) begin
        sample_value <= adc_count;
        saturated    <= adc_count == AllOnes;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      min_value <= AllOnes;
      max_value <= '0;
    end else if (clear_minmax && sample_strobe) begin
      min_value <= sample_value;
      max_value <= sample_value;
    end else if (clear_minmax) begin
      min_value <= AllOnes;
      max_value <= '0;
    end else if (sample_strobe) begin
      if (sample_value < min_value) min_value <= sample_value;
      if (sample_value > max_value) max_value <= sample_value;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || sample_strobe) begin
      stale_cnt <= '0;
    end else if (stale_cnt != StaleMax) begin
      stale_cnt <= stale_cnt + StaleWidth'(1);
    end
  end

  assign stale = stale_cnt == StaleMax;

`ifdef ADC_MON_IIR_EN
  logic [WIDTH-1:0]        filt;
  logic                    filt_seeded;
  logic                    filt_strobe;
  logic signed [WIDTH:0]   filt_diff;
  logic signed [WIDTH:0]   filt_sum;
  logic [WIDTH-1:0]        filt_next;

  always_comb begin
    filt_diff = $signed({1'b0, sample_value}) - $signed({1'b0, filt});
    filt_sum  = $signed({1'b0, filt}) + (filt_diff >>> IirShift);
    // The top bit is the sign of the WIDTH+1 result; a negative sum clamps to zero.
    filt_next = filt_sum[WIDTH] ? '0 : filt_sum[WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      filt        <= '0;
      filt_seeded <= 1'b0;
      filt_strobe <= 1'b0;
    end else begin
      filt_strobe <= sample_strobe;
      if (sample_strobe) begin
        filt        <= filt_seeded ? filt_next : sample_value;
        filt_seeded <= 1'b1;
      end
    end
  end

  assign fsm_strobe = filt_strobe;
  assign fsm_value  = filt;
`else
  assign fsm_strobe = sample_strobe;
  assign fsm_value  = sample_value;
`endif

  adc_hysteresis_fsm #(
    .WIDTH    (WIDTH),
    .DEBOUNCE (DEBOUNCE)
  ) u_fsm (
    .clock       (clock),
    .reset       (reset),
    .strobe      (fsm_strobe),
    .value       (fsm_value),
    .thresh_high (thresh_high),
    .thresh_low  (thresh_low),
    .alarm       (alarm)
  );

endmodule

// File: tb/tb_adc_threshold_monitor.sv
// Scoreboard bench: stimulus queues expected samples, a monitor checks each strobe.
// Expected alarm values are hand-computed for thresh_high=0x08000, thresh_low=0x04000.
module tb_adc_threshold_monitor;

  typedef struct {
    logic [19:0] value;
    logic        sat;
    logic        alarm;
    logic [19:0] mn;
    logic [19:0] mx;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] adc_count = '0;
  logic [19:0] thresh_high = 20'h08000;
  logic [19:0] thresh_low = 20'h04000;
  logic        clear_minmax = 1'b0;
  logic        sample_strobe;
  logic [19:0] sample_value;
  logic        alarm;
  logic [19:0] min_value;
  logic [19:0] max_value;
  logic        stale;
  logic        saturated;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [19:0] mdl_min = 20'hFFFFF;
  logic [19:0] mdl_max = 20'h00000;

  logic [19:0] vec_val[17] = '{20'h01000, 20'h09000, 20'h09001, 20'h09002, 20'h07000,
                               20'h09100, 20'h09200, 20'h09300, 20'h09400,
                               20'h03000, 20'h03001, 20'h03002, 20'h05000,
                               20'h03100, 20'h03200, 20'h03300, 20'h03400};
  logic        vec_alarm[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b0};

  adc_threshold_monitor #(
    .WIDTH        (20),
    .DEBOUNCE     (4),
    .STALE_CYCLES (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .adc_count     (adc_count),
    .thresh_high   (thresh_high),
    .thresh_low    (thresh_low),
    .clear_minmax  (clear_minmax),
    .sample_strobe (sample_strobe),
    .sample_value  (sample_value),
    .alarm         (alarm),
    .min_value     (min_value),
    .max_value     (max_value),
    .stale         (stale),
    .saturated     (saturated)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_strobe", 32'(sample_strobe), 32'h0);
    check("rst_value", 32'(sample_value), 32'h0);
    check("rst_alarm", 32'(alarm), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);
    check("rst_saturated", 32'(saturated), 32'h0);
    check("rst_min", 32'(min_value), 32'hFFFFF);
    check("rst_max", 32'(max_value), 32'h0);
  endtask

  // Queue the expected response, then present the value and optionally clear on the strobe cycle.
  task automatic send(input logic [19:0] v, input logic clr, input logic exp_alarm);
    exp_t e;
    if (clr) begin
      mdl_min = v;
      mdl_max = v;
    end else begin
      if (v < mdl_min) mdl_min = v;
      if (v > mdl_max) mdl_max = v;
    end
    e.value = v;
    e.sat   = (v == 20'hFFFFF);
    e.alarm = exp_alarm;
    e.mn    = mdl_min;
    e.mx    = mdl_max;
    sb.push_back(e);
    @(posedge clock); #1 adc_count = v;
    @(posedge clock); #1 clear_minmax = clr;
    @(posedge clock); #1 clear_minmax = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && sample_strobe) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", 32'(sample_value), 32'hDEAD);
        end else begin
          e = sb.pop_front();
          check("sample_value", 32'(sample_value), 32'(e.value));
          check("saturated", 32'(saturated), 32'(e.sat));
          @(negedge clock);
          check("strobe_single", 32'(sample_strobe), 32'h0);
          check("alarm", 32'(alarm), 32'(e.alarm));
          check("min_value", 32'(min_value), 32'(e.mn));
          check("max_value", 32'(max_value), 32'(e.mx));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: simulation did not reach the end, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_state();

    for (int i = 0; i < 17; i++) send(vec_val[i], 1'b0, vec_alarm[i]);

    // Stale watchdog: the 16th cycle after a strobe raises stale.
    send(20'h02000, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      if (k == 15) check("stale_early", 32'(stale), 32'h0);
      if (k == 16) check("stale_set", 32'(stale), 32'h1);
    end
    send(20'h02100, 1'b0, 1'b0);
    @(negedge clock);
    check("stale_cleared", 32'(stale), 32'h0);

    send(20'hFFFFF, 1'b0, 1'b0);
    send(20'h00200, 1'b1, 1'b0);

    // Clear with no strobe restarts tracking.
    @(posedge clock); #1 clear_minmax = 1'b1;
    @(posedge clock); #1 clear_minmax = 1'b0;
    @(negedge clock);
    check("clear_min", 32'(min_value), 32'hFFFFF);
    check("clear_max", 32'(max_value), 32'h0);
    mdl_min = 20'hFFFFF;
    mdl_max = 20'h00000;

    // Reset two samples into a high debounce; the count must restart from zero.
    send(20'h09000, 1'b0, 1'b0);
    send(20'h09001, 1'b0, 1'b0);
    @(posedge clock); #1 adc_count = 20'h00000; reset = 1'b1;
    @(posedge clock);
    @(posedge clock); #1 reset = 1'b0;
    mdl_min = 20'hFFFFF;
    mdl_max = 20'h00000;
    @(negedge clock);
    check_reset_state();
    send(20'h09100, 1'b0, 1'b0);
    send(20'h09200, 1'b0, 1'b0);
    send(20'h09300, 1'b0, 1'b0);
    send(20'h09400, 1'b0, 1'b1);

    repeat (4) @(posedge clock);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_threshold_monitor.md
Name: adc_threshold_monitor

Overview:
- Sits directly downstream of the pseudo-ADC RC-timing stage and consumes its 20-bit averaged count (adc_count), which has no valid strobe.
- Detects each new averaged result and presents it as a registered sample.
- Runs a debounced hysteresis alarm FSM, tracks min/max, and flags a stalled or saturated converter.
- Outputs go to the status/readout logic.

Parameters:
- WIDTH, 20: sample width; matches the upstream adc_count.
- DEBOUNCE, 4: consecutive qualifying new samples needed to enter or leave alarm; legal range 1..15.
- STALE_CYCLES, 2097152: clocks without a new sample before stale asserts; must be ≥2.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- adc_count  in  WIDTH  averaged count from the upstream pseudo ADC.
- thresh_high  in  WIDTH  alarm trip level; quasi-static.
- thresh_low  in  WIDTH  alarm release level; quasi-static.
- clear_minmax  in  1  one-cycle pulse that restarts min/max tracking.
- sample_strobe  out  1  one-cycle pulse: sample_value was updated this cycle.
- sample_value  out  WIDTH  last new sample.
- alarm  out  1  debounced over-threshold flag.
- min_value  out  WIDTH  minimum sample since reset or clear.
- max_value  out  WIDTH  maximum sample since reset or clear.
- stale  out  1  no new sample for STALE_CYCLES clocks.
- saturated  out  1  last sample equals the all-ones value (20'hFFFFF, upstream counter pinned).

Behaviour:
- Clocking and reset: single clock, synchronous active-high reset (port names clock, reset). All state updates only on the rising edge of clock.
- Reset values:
  - sample_strobe=0, sample_value=0, alarm=0, stale=0, saturated=0.
  - min_value=all-ones, max_value=0.
  - FSM=NORMAL, debounce count=0, stale counter=0, prev_count=0.
- New-sample detection:
  - adc_count is captured each cycle into prev_count.
  - A new sample is declared when adc_count != prev_count.
  - If that is seen at cycle N, then at cycle N+1: sample_strobe=1, sample_value=that adc_count, and saturated is updated.
  - Two identical consecutive upstream results are indistinguishable and are not reported; the stale watchdog covers this case.
- Min/max:
  - Updated on a strobe cycle; new values are visible the following cycle.
  - clear_minmax alone: min=all-ones, max=0.
  - clear_minmax coincident with a strobe: min=max=sample_value.
- Alarm FSM (states NORMAL, PEND_HIGH, ALARM, PEND_LOW):
  - Evaluated only on strobe cycles; alarm updates one cycle after the strobe.
  - Comparisons are unsigned and strict.
  - NORMAL: if sample > thresh_high, go to PEND_HIGH with cnt=1. If DEBOUNCE=1, go directly to ALARM.
  - PEND_HIGH: if sample > thresh_high, cnt+1; when cnt reaches DEBOUNCE, go to ALARM. Otherwise return to NORMAL with cnt=0.
  - ALARM: if sample < thresh_low, go to PEND_LOW with cnt=1. If DEBOUNCE=1, go directly to NORMAL.
  - PEND_LOW: if sample < thresh_low, cnt+1; when cnt reaches DEBOUNCE, go to NORMAL. Otherwise return to ALARM with cnt=0.
  - alarm=1 in ALARM and PEND_LOW.
  - thresh_low > thresh_high is not guarded; the rules above still apply literally.
- Stale watchdog:
  - Counter clears on each strobe and otherwise increments, saturating at STALE_CYCLES-1.
  - stale=1 while the counter equals STALE_CYCLES-1; it clears in the cycle after the next strobe.
- Reset mid-debounce abandons the count; the FSM returns to NORMAL.

Optional Feature:
- Macro: ADC_MON_IIR_EN.
- Defined:
  - A first-order IIR filter, filt <= filt + ((sample - filt) >>> 3), runs on strobe cycles. Arithmetic is signed WIDTH+1; the result is clamped to 0..all-ones.
  - The filter seeds with the first sample after reset.
  - The FSM compares filt instead of the raw sample, which adds one cycle to alarm latency.
  - Min/max and saturated still use the raw sample.
- Undefined: no filter register; the FSM compares sample_value directly.

Decomposition:
- Shared package adc_mon_pkg holds:
  - the FSM state enum;
  - the all-ones saturation constant;
  - the debounce counter width (4);
  - the IIR shift constant (3).
- One natural sub-module, adc_hysteresis_fsm: inputs strobe, value and both thresholds; outputs alarm.

Test Plan:
- Reset, then step adc_count 0→0x01000 and hold: sample_strobe pulses once at N+1, sample_value=0x01000, min=max=0x01000 on the next cycle.
- thresh_high=0x08000, thresh_low=0x04000, DEBOUNCE=4, samples 0x09000,0x09001,0x09002 then 0x07000: alarm stays 0 and the FSM returns to NORMAL. Then four samples >0x08000: alarm=1 one cycle after the 4th strobe.
- From ALARM, send three samples 0x03000 then 0x05000: alarm stays 1. Then four samples 0x03000: alarm=0 after the 4th strobe.
- Hold adc_count constant with STALE_CYCLES=16: stale=1 at the 16th cycle after the last strobe. Then change the input: stale=0 the cycle after the strobe.
- Drive adc_count=0xFFFFF: saturated=1 with the strobe. Then pulse clear_minmax in the same cycle as a strobe of 0x00200: min=max=0x00200.
- With ADC_MON_IIR_EN, step 0→0x10000 and hold-toggle by ±1: the alarm at thresh_high=0x08000 trips only after the filtered value crosses it; verify each filt value against the reference formula.
